// File: rtl/aes_selftest_pkg.sv
// Shared types and constants for the AES known-answer-test sequencer.
// Optional build macro used by aes_selftest_seq: AES_SELFTEST_CAPTURE_EN.
package aes_selftest_pkg;

   localparam int AES_BLK_W   = 128;
   localparam int DEF_KEY_W   = 256;
   localparam int DEF_NUM_VEC = 16;
   localparam int DEF_TIMEOUT = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_START,
      ST_WAIT,
      ST_CHECK,
      ST_FIN
   } state_t;

   // Vector index width; a single-vector run still needs one address bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/aes_selftest_seq_if.sv
// Vector-memory and AES-core signal bundle seen by the KAT sequencer.
//
// Handshake semantics (both channels, no backpressure):
//   vector memory : vec_rd_en is a one-cycle read strobe with vec_addr; the
//                   memory returns vec_key/vec_pt/vec_ct exactly one cycle later.
//   AES core      : core_start is a one-cycle request; core_key/core_plaintext
//                   stay stable from core_start until the first cycle with
//                   core_done=1, and core_ciphertext is valid on that cycle.
//                   core_done may be a pulse or a level; only its first high
//                   cycle after core_start is consumed.
interface aes_selftest_seq_if
   import aes_selftest_pkg::*;
#(
   parameter int KEY_W = DEF_KEY_W,
   parameter int IDX_W = 4
);

   logic                 vec_rd_en;
   logic [IDX_W-1:0]     vec_addr;
   logic [KEY_W-1:0]     vec_key;
   logic [AES_BLK_W-1:0] vec_pt;
   logic [AES_BLK_W-1:0] vec_ct;

   logic                 core_start;
   logic [KEY_W-1:0]     core_key;
   logic [AES_BLK_W-1:0] core_plaintext;
   logic [AES_BLK_W-1:0] core_ciphertext;
   logic                 core_done;

   // Sequencer side
   modport master (
      output vec_rd_en, vec_addr, core_start, core_key, core_plaintext,
      input  vec_key, vec_pt, vec_ct, core_ciphertext, core_done
   );

   // Vector memory / AES core side
   modport slave (
      input  vec_rd_en, vec_addr, core_start, core_key, core_plaintext,
      output vec_key, vec_pt, vec_ct, core_ciphertext, core_done
   );

endinterface

// File: rtl/aes_selftest_seq.sv
// On-chip AES known-answer-test sequencer: walks NUM_VEC stored vectors,
// drives each into the core, compares the ciphertext and keeps statistics.
// Build macro AES_SELFTEST_CAPTURE_EN: when defined, fail_ct holds the
// ciphertext of the first failing vector; otherwise fail_ct is tied to 0.
module aes_selftest_seq
   import aes_selftest_pkg::*;
#(
   parameter  int KEY_W   = DEF_KEY_W,
   parameter  int NUM_VEC = DEF_NUM_VEC,
   parameter  int TIMEOUT = DEF_TIMEOUT,
   localparam int IDX_W   = idx_width(NUM_VEC),
   localparam int CNT_W   = $clog2(NUM_VEC + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run,
   input  logic                 stop_on_fail,
   aes_selftest_seq_if.master   bus,
   output logic                 busy,
   output logic                 done,
   output logic                 all_pass,
   output logic [CNT_W-1:0]     pass_cnt,
   output logic [CNT_W-1:0]     fail_cnt,
   output logic [CNT_W-1:0]     timeout_cnt,
   output logic [IDX_W-1:0]     first_fail_idx,
   output logic                 first_fail_valid,
   output logic [AES_BLK_W-1:0] fail_ct,
   output state_t               state_dbg
);

   localparam int              TMR_W    = $clog2(TIMEOUT + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   state_t               state_q;
   logic [IDX_W-1:0]     idx_q;
   logic                 stop_q;
   logic                 rd_en_q;
   logic                 start_q;
   logic [KEY_W-1:0]     key_q;
   logic [AES_BLK_W-1:0] pt_q;
   logic [AES_BLK_W-1:0] exp_q;
   logic [AES_BLK_W-1:0] res_q;
   logic                 timed_out_q;
   logic [TMR_W-1:0]     tmr_q;
   logic                 chk_pass;

   // Result of the vector currently in CHECK; a timeout always fails.
   assign chk_pass = (res_q == exp_q) && !timed_out_q;

   assign bus.vec_rd_en      = rd_en_q;
   assign bus.vec_addr       = idx_q;
   assign bus.core_start     = start_q;
   assign bus.core_key       = key_q;
   assign bus.core_plaintext = pt_q;
   assign state_dbg          = state_q;

   // Sequencer FSM with registered strobes, operand holding registers and statistics.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= ST_IDLE;
         idx_q            <= '0;
         stop_q           <= 1'b0;
         rd_en_q          <= 1'b0;
         start_q          <= 1'b0;
         key_q            <= '0;
         pt_q             <= '0;
         exp_q            <= '0;
         res_q            <= '0;
         timed_out_q      <= 1'b0;
         tmr_q            <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         all_pass         <= 1'b0;
         pass_cnt         <= '0;
         fail_cnt         <= '0;
         timeout_cnt      <= '0;
         first_fail_idx   <= '0;
         first_fail_valid <= 1'b0;
      end else begin
         rd_en_q <= 1'b0;
         start_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_FIN: begin
               if (run) begin
                  state_q          <= ST_FETCH;
                  idx_q            <= '0;
                  stop_q           <= stop_on_fail;
                  rd_en_q          <= 1'b1;
                  busy             <= 1'b1;
                  done             <= 1'b0;
                  all_pass         <= 1'b0;
                  pass_cnt         <= '0;
                  fail_cnt         <= '0;
                  timeout_cnt      <= '0;
                  first_fail_idx   <= '0;
                  first_fail_valid <= 1'b0;
               end
            end
            ST_FETCH: begin
               state_q <= ST_LOAD;
            end
            ST_LOAD: begin
               key_q   <= bus.vec_key;
               pt_q    <= bus.vec_pt;
               exp_q   <= bus.vec_ct;
               start_q <= 1'b1;
               state_q <= ST_START;
            end
            ST_START: begin
               tmr_q       <= '0;
               timed_out_q <= 1'b0;
               state_q     <= ST_WAIT;
            end
            ST_WAIT: begin
               // core_done is checked first so a response on the last allowed cycle still counts.
               if (bus.core_done) begin
                  res_q   <= bus.core_ciphertext;
                  state_q <= ST_CHECK;
               end else if (tmr_q == TMR_LAST) begin
                  res_q       <= '0;
                  timed_out_q <= 1'b1;
                  state_q     <= ST_CHECK;
               end else begin
                  tmr_q <= tmr_q + TMR_W'(1);
               end
            end
            ST_CHECK: begin
               if (chk_pass) begin
                  pass_cnt <= pass_cnt + CNT_W'(1);
               end else begin
                  fail_cnt <= fail_cnt + CNT_W'(1);
                  if (timed_out_q) timeout_cnt <= timeout_cnt + CNT_W'(1);
                  if (!first_fail_valid) begin
                     first_fail_idx   <= idx_q;
                     first_fail_valid <= 1'b1;
                  end
               end
               if ((idx_q == LAST_IDX) || (!chk_pass && stop_q)) begin
                  state_q  <= ST_FIN;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  all_pass <= chk_pass && (fail_cnt == '0);
               end else begin
                  idx_q   <= idx_q + IDX_W'(1);
                  rd_en_q <= 1'b1;
                  state_q <= ST_FETCH;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef AES_SELFTEST_CAPTURE_EN
   logic [AES_BLK_W-1:0] fail_ct_q;

   // Capture the returned ciphertext of the first failing vector (res_q is 0 after a timeout).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fail_ct_q <= '0;
      end else if ((state_q == ST_IDLE || state_q == ST_FIN) && run) begin
         fail_ct_q <= '0;
      end else if (state_q == ST_CHECK && !chk_pass && !first_fail_valid) begin
         fail_ct_q <= res_q;
      end
   end

   assign fail_ct = fail_ct_q;
`else
   assign fail_ct = '0;
`endif

endmodule
